mac: RTL and testbench

// - Multiply-accumulate unit for one neuron of the hardware neural network.
// - Accumulates sign-magnitude input x weight products over successive clocks.
// - Adds a sign-magnitude bias to the running sum; presents a saturated 8-bit sign-magnitude result.
// - Sits between the layer controller (drives rst_Acc/ld_Acc) and the weight/input/bias memories.

---
 rtl/mac.sv | 90 +++++++++
 tb/tb_mac.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mac.sv
// Multiply-accumulate unit for one neuron.
// Sign-magnitude input x weight products are summed into a saturating two's-complement
// accumulator; the bias is added combinationally and the result is clamped and re-encoded
// as sign-magnitude. Define MAC_RELU_EN to force negative results to zero.
module mac #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rst_Acc,
    input  logic              ld_Acc,
    input  logic [DATA_W-1:0] cur_input,
    input  logic [DATA_W-1:0] cur_weight,
    input  logic [DATA_W-1:0] cur_bios,
    output logic [DATA_W-1:0] result
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    // One guard bit so acc + product (and acc + bias) can be compared before clamping.
    localparam int unsigned SUM_W  = ACC_W + 1;

    localparam logic signed [SUM_W-1:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN = -ACC_MAX;
    localparam logic [SUM_W-1:0]        MAG_MAX = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};

    // Sign-magnitude to two's complement; negative zero decodes to 0.
    function automatic logic signed [DATA_W-1:0] decode(input logic [DATA_W-1:0] v);
        logic signed [DATA_W-1:0] mag;
        mag = {1'b0, v[DATA_W-2:0]};
        return v[DATA_W-1] ? -mag : mag;
    endfunction

    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [DATA_W-1:0] in_dec;
    logic signed [DATA_W-1:0] w_dec;
    logic signed [DATA_W-1:0] bias_dec;
    logic signed [PROD_W-1:0] in_ext;
    logic signed [PROD_W-1:0] w_ext;
    logic signed [PROD_W-1:0] product;
    logic signed [SUM_W-1:0]  acc_sum;
    logic signed [SUM_W-1:0]  out_sum;
    logic [SUM_W-1:0]         out_abs;
    logic                     out_neg;
    logic [DATA_W-2:0]        out_mag;

    // Decode operands and form the saturated next accumulator value.
    always_comb begin
        in_dec   = decode(cur_input);
        w_dec    = decode(cur_weight);
        bias_dec = decode(cur_bios);
        in_ext   = {{DATA_W{in_dec[DATA_W-1]}}, in_dec};
        w_ext    = {{DATA_W{w_dec[DATA_W-1]}}, w_dec};
        product  = in_ext * w_ext;
        acc_sum  = {acc_q[ACC_W-1], acc_q} + {{(SUM_W-PROD_W){product[PROD_W-1]}}, product};
        if (acc_sum > ACC_MAX) begin
            acc_d = ACC_MAX[ACC_W-1:0];
        end else if (acc_sum < ACC_MIN) begin
            acc_d = ACC_MIN[ACC_W-1:0];
        end else begin
            acc_d = acc_sum[ACC_W-1:0];
        end
    end

    // Accumulator register: reset, then clear, then load; otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= '0;
        end else if (rst_Acc) begin
            acc_q <= '0;
        end else if (ld_Acc) begin
            acc_q <= acc_d;
        end
    end

    // Add bias, clamp the magnitude and encode; zero is always positive zero.
    always_comb begin
        out_sum = {acc_q[ACC_W-1], acc_q} + {{(SUM_W-DATA_W){bias_dec[DATA_W-1]}}, bias_dec};
        out_neg = out_sum[SUM_W-1];
        out_abs = out_neg ? -out_sum : out_sum;
        out_mag = (out_abs > MAG_MAX) ? {(DATA_W-1){1'b1}} : out_abs[DATA_W-2:0];
`ifdef MAC_RELU_EN
        result = out_neg ? '0 : {1'b0, out_mag};
`else
        result = {out_neg, out_mag};
`endif
    end

endmodule

// File: tb/tb_mac.sv
// Scoreboard bench for mac: each step pushes its expected result, and a monitor
// pops and compares on the falling edge while inputs are stable.
module tb_mac;

    logic       clk;
    logic       rst;
    logic       rst_Acc;
    logic       ld_Acc;
    logic [7:0] cur_input;
    logic [7:0] cur_weight;
    logic [7:0] cur_bios;
    logic [7:0] result;

    logic [7:0] exp_q[$];
    string      name_q[$];
    int         n_checks;
    int         n_fail;

    mac #(
        .DATA_W(8),
        .ACC_W (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rst_Acc   (rst_Acc),
        .ld_Acc    (ld_Acc),
        .cur_input (cur_input),
        .cur_weight(cur_weight),
        .cur_bios  (cur_bios),
        .result    (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Negative expected results become zero in the ReLU build.
    function automatic logic [7:0] sgn(input logic [7:0] v);
`ifdef MAC_RELU_EN
        return v[7] ? 8'h00 : v;
`else
        return v;
`endif
    endfunction

    // Monitor: compare the DUT result against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [7:0] e;
            string      n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            n_checks++;
            if (result !== e) begin
                n_fail++;
                $display("FAIL %s: result=%02h expected=%02h", n, result, e);
            end
        end
    end

    // Apply one cycle of inputs, let the edge happen, then queue the expectation.
    task automatic step(input logic r, input logic ra, input logic ld, input logic [7:0] a,
                        input logic [7:0] w, input logic [7:0] b, input logic [7:0] e,
                        input string n);
        rst        = r;
        rst_Acc    = ra;
        ld_Acc     = ld;
        cur_input  = a;
        cur_weight = w;
        cur_bios   = b;
        @(posedge clk);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        rst_Acc    = 1'b0;
        ld_Acc     = 1'b0;
        cur_input  = 8'h00;
        cur_weight = 8'h00;
        cur_bios   = 8'h00;

        // Reset, including reset winning over a load.
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, "reset_zero");
        step(1'b0, 1'b0, 1'b1, 8'h03, 8'h03, 8'h83, sgn(8'h83), "reset_bias");
        step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h05, 8'h05, "clear");

        // Accumulate 9, -18, -16 with bias 5.
        step(1'b1, 1'b0, 1'b1, 8'h03, 8'h03, 8'h05, 8'h0E, "acc1");
        step(1'b1, 1'b0, 1'b1, 8'h03, 8'h86, 8'h05, sgn(8'h84), "acc2");
        step(1'b1, 1'b0, 1'b1, 8'h02, 8'h88, 8'h05, sgn(8'h94), "acc3");

        // Hold, then bias change is seen without an edge load.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h7F, 8'h7F, 8'h05, sgn(8'h94), "hold");
        end
        step(1'b1, 1'b0, 1'b0, 8'h7F, 8'h7F, 8'h00, sgn(8'h99), "hold_bias0");

        // Clear wins over load.
        step(1'b1, 1'b1, 1'b1, 8'h05, 8'h05, 8'h03, 8'h03, "clear_prio");

        // Positive and negative output saturation.
        step(1'b1, 1'b0, 1'b1, 8'h7F, 8'h7F, 8'h00, 8'h7F, "sat_pos1");
        step(1'b1, 1'b0, 1'b1, 8'h7F, 8'h7F, 8'h00, 8'h7F, "sat_pos2");
        step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, "clear2");
        step(1'b1, 1'b0, 1'b1, 8'hFF, 8'h7F, 8'h00, sgn(8'hFF), "sat_neg");

        // Zero sum encodes as 8'h00.
        step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, "clear3");
        step(1'b1, 1'b0, 1'b1, 8'h03, 8'h03, 8'h89, 8'h00, "zero_sum");

        // Negative-zero operands contribute nothing.
        step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, "clear4");
        step(1'b1, 1'b0, 1'b1, 8'h80, 8'h7F, 8'h80, 8'h00, "neg_zero");

        // Positive result, then reset mid-sequence, then accumulate afresh.
        step(1'b1, 1'b0, 1'b1, 8'h03, 8'h03, 8'h05, 8'h0E, "pos_sum");
        step(1'b0, 1'b0, 1'b1, 8'h03, 8'h03, 8'h05, 8'h05, "rst_mid");
        step(1'b1, 1'b0, 1'b1, 8'h01, 8'h01, 8'h00, 8'h01, "after_rst");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: outstanding=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
